// File: rtl/ldpc_loop_checker.sv
// Checks the LDPC loop output against a regenerated PRBS payload and the decoder
// status, and emits one error-summary result beat per block.
//
// state  | meaning
// IDLE   | waiting for an accepted cfg_start
// DATA   | comparing in-length data beats against the LFSR
// DRAIN  | block overran its length; discarding beats up to tlast
// STATUS | waiting for the decoder status beat of this block
// RESULT | presenting the registered result beat until accepted
module ldpc_loop_checker #(
    parameter int DATA_WIDTH   = 32,
    parameter int STATUS_WIDTH = 32,
    parameter int LEN_WIDTH    = 16
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    cfg_start,
    input  logic [31:0]             cfg_seed,
    input  logic [LEN_WIDTH-1:0]    cfg_block_len,
    input  logic [LEN_WIDTH-1:0]    cfg_num_blocks,
    input  logic [DATA_WIDTH-1:0]   s_axis_dout_tdata,
    input  logic                    s_axis_dout_tvalid,
    input  logic                    s_axis_dout_tlast,
    output logic                    s_axis_dout_tready,
    input  logic [STATUS_WIDTH-1:0] s_axis_status_tdata,
    input  logic                    s_axis_status_tvalid,
    output logic                    s_axis_status_tready,
    output logic [31:0]             m_axis_result_tdata,
    output logic                    m_axis_result_tvalid,
    output logic                    m_axis_result_tlast,
    input  logic                    m_axis_result_tready,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             err_block_cnt
);

    localparam logic [31:0]          LFSR_POLY = 32'h8020_0003;
    localparam logic [LEN_WIDTH-1:0] LEN_ONE   = LEN_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_DRAIN,
        S_STATUS,
        S_RESULT
    } state_t;

    state_t                 state_q, state_d;
    logic [31:0]            lfsr_q, lfsr_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [LEN_WIDTH-1:0]   nblk_q, nblk_d;
    logic [LEN_WIDTH-1:0]   beat_q, beat_d;
    logic [LEN_WIDTH-1:0]   blk_q, blk_d;
    logic [15:0]            word_err_q, word_err_d;
    logic                   short_q, short_d;
    logic                   long_q, long_d;
    logic [31:0]            res_data_q, res_data_d;
    logic                   res_last_q, res_last_d;
    logic [15:0]            err_cnt_q, err_cnt_d;
    logic                   done_q, done_d;

    logic [31:0]            lfsr_adv;
    logic                   dout_hs;
    logic                   status_hs;
    logic                   result_hs;
    logic                   start_ok;
    logic                   beat_is_last;

    // Only bit 0 of the decoder status carries meaning here.
    generate
        if (STATUS_WIDTH > 1) begin : g_status_unused
            logic status_unused;
            assign status_unused = ^s_axis_status_tdata[STATUS_WIDTH-1:1];
        end
    endgenerate

    assign lfsr_adv     = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_POLY : 32'h0);
    assign beat_is_last = (beat_q == (len_q - LEN_ONE));
    assign start_ok     = cfg_start && (cfg_block_len != '0) && (cfg_num_blocks != '0);

    assign s_axis_dout_tready   = (state_q == S_DATA) || (state_q == S_DRAIN);
    assign s_axis_status_tready = (state_q == S_STATUS);
    assign m_axis_result_tvalid = (state_q == S_RESULT);
    assign m_axis_result_tdata  = res_data_q;
    assign m_axis_result_tlast  = res_last_q;
    assign busy                 = (state_q != S_IDLE);
    assign done                 = done_q;
    assign err_block_cnt        = err_cnt_q;

    assign dout_hs   = s_axis_dout_tready && s_axis_dout_tvalid;
    assign status_hs = s_axis_status_tready && s_axis_status_tvalid;
    assign result_hs = m_axis_result_tvalid && m_axis_result_tready;

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        len_d      = len_q;
        nblk_d     = nblk_q;
        beat_d     = beat_q;
        blk_d      = blk_q;
        word_err_d = word_err_q;
        short_d    = short_q;
        long_d     = long_q;
        res_data_d = res_data_q;
        res_last_d = res_last_q;
        err_cnt_d  = err_cnt_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    len_d      = cfg_block_len;
                    nblk_d     = cfg_num_blocks;
                    lfsr_d     = (cfg_seed == 32'h0) ? 32'h0000_0001 : cfg_seed;
                    beat_d     = '0;
                    blk_d      = '0;
                    word_err_d = '0;
                    short_d    = 1'b0;
                    long_d     = 1'b0;
                    err_cnt_d  = '0;
                    state_d    = S_DATA;
                end
            end

            S_DATA: begin
                if (dout_hs) begin
                    if ((s_axis_dout_tdata != lfsr_q[DATA_WIDTH-1:0]) && (word_err_q != 16'hFFFF)) begin
                        word_err_d = word_err_q + 16'd1;
                    end
                    lfsr_d = lfsr_adv;
                    beat_d = beat_q + LEN_ONE;
                    if (beat_is_last) begin
                        if (s_axis_dout_tlast) begin
                            state_d = S_STATUS;
                        end else begin
                            long_d  = 1'b1;
                            state_d = S_DRAIN;
                        end
                    end else if (s_axis_dout_tlast) begin
                        short_d = 1'b1;
                        state_d = S_STATUS;
                    end
                end
            end

            S_DRAIN: begin
                if (dout_hs && s_axis_dout_tlast) begin
                    state_d = S_STATUS;
                end
            end

            S_STATUS: begin
                if (status_hs) begin
                    res_data_d = {blk_q[7:0], 5'd0, s_axis_status_tdata[0],
                                  long_q, short_q, word_err_q};
                    res_last_d = (blk_q == (nblk_q - LEN_ONE));
                    state_d    = S_RESULT;
                end
            end

            S_RESULT: begin
                if (result_hs) begin
                    if ((res_data_q[18:0] != 19'd0) && (err_cnt_q != 16'hFFFF)) begin
                        err_cnt_d = err_cnt_q + 16'd1;
                    end
                    if (res_last_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        blk_d      = blk_q + LEN_ONE;
                        beat_d     = '0;
                        word_err_d = '0;
                        short_d    = 1'b0;
                        long_d     = 1'b0;
                        state_d    = S_DATA;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= S_IDLE;
            lfsr_q     <= 32'h0000_0001;
            len_q      <= '0;
            nblk_q     <= '0;
            beat_q     <= '0;
            blk_q      <= '0;
            word_err_q <= '0;
            short_q    <= 1'b0;
            long_q     <= 1'b0;
            res_data_q <= '0;
            res_last_q <= 1'b0;
            err_cnt_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            len_q      <= len_d;
            nblk_q     <= nblk_d;
            beat_q     <= beat_d;
            blk_q      <= blk_d;
            word_err_q <= word_err_d;
            short_q    <= short_d;
            long_q     <= long_d;
            res_data_q <= res_data_d;
            res_last_q <= res_last_d;
            err_cnt_q  <= err_cnt_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_ldpc_loop_checker.sv
// Randomized and directed bench for ldpc_loop_checker; expected results come from
// a block-level PRBS model that counts compared beats, errors and length faults.
module tb_ldpc_loop_checker;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        cfg_start;
    logic [31:0] cfg_seed;
    logic [15:0] cfg_block_len;
    logic [15:0] cfg_num_blocks;
    logic [31:0] dout_tdata;
    logic        dout_tvalid;
    logic        dout_tlast;
    logic        dout_tready;
    logic [31:0] st_tdata;
    logic        st_tvalid;
    logic        st_tready;
    logic [31:0] res_tdata;
    logic        res_tvalid;
    logic        res_tlast;
    logic        res_tready;
    logic        busy;
    logic        done;
    logic [15:0] err_block_cnt;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mdl_lfsr;
    int          mdl_errblk;

    always #5 aclk = ~aclk;

    ldpc_loop_checker dut (
        .aclk                 (aclk),
        .aresetn              (aresetn),
        .cfg_start            (cfg_start),
        .cfg_seed             (cfg_seed),
        .cfg_block_len        (cfg_block_len),
        .cfg_num_blocks       (cfg_num_blocks),
        .s_axis_dout_tdata    (dout_tdata),
        .s_axis_dout_tvalid   (dout_tvalid),
        .s_axis_dout_tlast    (dout_tlast),
        .s_axis_dout_tready   (dout_tready),
        .s_axis_status_tdata  (st_tdata),
        .s_axis_status_tvalid (st_tvalid),
        .s_axis_status_tready (st_tready),
        .m_axis_result_tdata  (res_tdata),
        .m_axis_result_tvalid (res_tvalid),
        .m_axis_result_tlast  (res_tlast),
        .m_axis_result_tready (res_tready),
        .busy                 (busy),
        .done                 (done),
        .err_block_cnt        (err_block_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l);
        int n;
        dout_tdata  = d;
        dout_tvalid = 1'b1;
        dout_tlast  = l;
        n = 0;
        while (dout_tready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("dout_rdy_timeout", 32'd0, 32'd1);
        tick();
        dout_tvalid = 1'b0;
        dout_tlast  = 1'b0;
    endtask

    task automatic start_run(input logic [31:0] seed, input int len, input int nb);
        bit acc;
        cfg_seed       = seed;
        cfg_block_len  = 16'(len);
        cfg_num_blocks = 16'(nb);
        cfg_start      = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_seed       = $urandom;
        cfg_block_len  = 16'($urandom_range(1, 9));
        cfg_num_blocks = 16'($urandom_range(1, 9));
        acc = (len != 0) && (nb != 0);
        check("start_busy", busy, acc);
        if (acc) begin
            mdl_lfsr   = (seed == 32'h0) ? 32'h1 : seed;
            mdl_errblk = 0;
            check("start_errcnt", err_block_cnt, 32'd0);
        end
    endtask

    task automatic run_block(input int len, input int nb, input logic [31:0] mask,
                             input logic [31:0] cx, input bit fail, input int idx,
                             input bit last, input int stall);
        logic [31:0] d, e, res;
        int          we, n;
        bit          sh, lg;
        we = 0;
        sh = (nb < len);
        lg = (nb > len);
        st_tdata  = ($urandom & 32'hFFFF_FFFE) | 32'(fail);
        st_tvalid = 1'b1;
        for (int i = 0; i < nb; i++) begin
            if (i < len) begin
                e = mdl_lfsr;
                d = mask[i] ? (e ^ cx) : e;
                if (d != e && we < 65535) we++;
                mdl_lfsr = lfsr_step(mdl_lfsr);
            end else begin
                d = $urandom;
            end
            repeat ($urandom_range(0, 1)) tick();
            send_beat(d, i == nb - 1);
        end
        check("status_rdy", st_tready, 32'd1);
        tick();
        st_tvalid = 1'b0;
        check("latency", res_tvalid, 32'd1);
        n = 0;
        while (res_tvalid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("res_timeout", 32'd0, 32'd1);
        res = {8'(idx), 5'd0, fail, lg, sh, 16'(we)};
        for (int k = 0; k < stall; k++) begin
            check("hold_valid", res_tvalid, 32'd1);
            check("hold_data", res_tdata, res);
            check("stall_dout_rdy", dout_tready, 32'd0);
            tick();
        end
        res_tready = 1'b1;
        check("res_data", res_tdata, res);
        check("res_last", res_tlast, last);
        tick();
        res_tready = 1'b0;
        if (res[18:0] != 19'd0 && mdl_errblk < 65535) mdl_errblk++;
        check("err_blk_cnt", err_block_cnt, mdl_errblk);
        check("done", done, last);
        check("busy_after", busy, !last);
        if (last) begin
            tick();
            check("done_pulse", done, 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int len, nblk, nb, mode, stall;
        logic [31:0] seed, mask;
        aresetn = 1'b0; cfg_start = 1'b0; cfg_seed = '0; cfg_block_len = '0;
        cfg_num_blocks = '0; dout_tdata = '0; dout_tvalid = 1'b0; dout_tlast = 1'b0;
        st_tdata = '0; st_tvalid = 1'b0; res_tready = 1'b0;
        mdl_lfsr = 32'h1; mdl_errblk = 0;
        repeat (2) tick();
        check("rst_busy", busy, 32'd0);
        check("rst_done", done, 32'd0);
        check("rst_errcnt", err_block_cnt, 32'd0);
        check("rst_res_valid", res_tvalid, 32'd0);
        check("rst_res_data", res_tdata, 32'd0);
        check("rst_dout_rdy", dout_tready, 32'd0);
        check("rst_status_rdy", st_tready, 32'd0);
        aresetn = 1'b1;
        tick();

        // zero length or zero block count must not start a run
        start_run(32'h1, 0, 3);
        start_run(32'h1, 3, 0);

        start_run(32'h1, 4, 1);
        run_block(4, 4, 32'h0, 32'h0, 1'b0, 0, 1'b1, 0);

        start_run(32'h1, 4, 1);
        run_block(4, 4, 32'h4, 32'h1, 1'b0, 0, 1'b1, 1);

        start_run(32'h1, 4, 2);
        run_block(4, 2, 32'h0, 32'h0, 1'b0, 0, 1'b0, 0);
        run_block(4, 4, 32'h0, 32'h0, 1'b0, 1, 1'b1, 0);

        start_run(32'h1, 4, 2);
        run_block(4, 6, 32'h0, 32'h0, 1'b1, 0, 1'b0, 2);
        run_block(4, 4, 32'h0, 32'h0, 1'b0, 1, 1'b1, 0);

        start_run(32'h1, 4, 2);
        cfg_seed = 32'hDEAD_BEEF; cfg_block_len = 16'd2; cfg_num_blocks = 16'd1;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        check("start_while_busy", busy, 32'd1);
        run_block(4, 4, 32'h0, 32'h0, 1'b0, 0, 1'b0, 5);
        run_block(4, 4, 32'h0, 32'h0, 1'b0, 1, 1'b1, 0);

        start_run(32'h1, 4, 2);
        run_block(4, 4, 32'h1, 32'h1, 1'b0, 0, 1'b0, 0);
        send_beat(mdl_lfsr, 1'b0);
        send_beat(lfsr_step(mdl_lfsr), 1'b0);
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        check("abort_busy", busy, 32'd0);
        check("abort_errcnt", err_block_cnt, 32'd0);
        check("abort_res_valid", res_tvalid, 32'd0);
        repeat (3) begin
            tick();
            check("abort_no_result", res_tvalid, 32'd0);
        end
        start_run(32'h1, 4, 1);
        run_block(4, 4, 32'h0, 32'h0, 1'b0, 0, 1'b1, 0);

        start_run(32'h0, 3, 1);
        run_block(3, 3, 32'h0, 32'h0, 1'b0, 0, 1'b1, 0);

        for (int r = 0; r < 30; r++) begin
            seed = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
            len  = $urandom_range(1, 8);
            nblk = $urandom_range(1, 4);
            start_run(seed, len, nblk);
            for (int b = 0; b < nblk; b++) begin
                mode = $urandom_range(0, 3);
                if (mode == 2)      nb = $urandom_range(1, len);
                else if (mode == 3) nb = len + $urandom_range(1, 3);
                else                nb = len;
                mask  = ($urandom_range(0, 2) == 0) ? $urandom : 32'h0;
                stall = $urandom_range(0, 3);
                run_block(len, nb, mask, $urandom | 32'h1, $urandom_range(0, 3) == 0,
                          b, b == nblk - 1, stall);
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ldpc_loop_checker.md
Name: ldpc_loop_checker

Overview:
Checker stage that sits directly downstream of the LDPC encoder/decoder loop. It consumes the loop's decoded data stream and the decoder status stream. It regenerates the expected PRBS payload, compares each data beat, and checks block length against tlast. It emits one result beat per block, giving an error summary to the test controller.

Parameters:
DATA_WIDTH, 32, data beat width; legal range 8..32; the expected word is lfsr[DATA_WIDTH-1:0]
STATUS_WIDTH, 32, decoder status beat width
LEN_WIDTH, 16, width of the block-length and block-count configuration fields

Ports:
aclk  in  1  clock; all logic is on the rising edge
aresetn  in  1  synchronous active-low reset
cfg_start  in  1  one-cycle pulse that begins a run; ignored unless the block is in IDLE
cfg_seed  in  32  LFSR seed; a value of 0 is replaced by 32'h0000_0001
cfg_block_len  in  LEN_WIDTH  beats per block; 0 means the start is ignored
cfg_num_blocks  in  LEN_WIDTH  blocks per run; 0 means the start is ignored
s_axis_dout_tdata  in  DATA_WIDTH  decoded data from the loop
s_axis_dout_tvalid  in  1
s_axis_dout_tlast  in  1  marks the last beat of a block
s_axis_dout_tready  out  1
s_axis_status_tdata  in  STATUS_WIDTH  decoder status, one beat per block; bit0=1 means decode failure
s_axis_status_tvalid  in  1
s_axis_status_tready  out  1
m_axis_result_tdata  out  32  per-block result word
m_axis_result_tvalid  out  1
m_axis_result_tlast  out  1  high on the result beat of the final block of the run
m_axis_result_tready  in  1
busy  out  1  high whenever the state is not IDLE
done  out  1  one-cycle pulse when the run completes
err_block_cnt  out  16  count of blocks with a nonzero result error field; saturates at 16'hFFFF; cleared on each start

Behaviour:
- Reset (aresetn=0 at an edge) forces the following, regardless of state:
  - state goes to IDLE
  - all tready and tvalid outputs go to 0; tdata goes to 0
  - busy=0, done=0, err_block_cnt=0, LFSR=1, all counters 0
- Reset mid-block discards the partial block; no result beat is emitted.
- LFSR: 32-bit Galois.
  - Next state = (s>>1) ^ (s[0] ? 32'h8020_0003 : 0).
  - The expected word is the current state; the LFSR advances only on a compared data handshake.
  - It is not reseeded between blocks within a run.
- FSM states: IDLE, DATA, DRAIN, STATUS, RESULT.
- IDLE:
  - All tready and tvalid outputs are 0.
  - cfg_start with nonzero len and count: latch the config, load the seed, clear the counters and err_block_cnt, then go to DATA.
- DATA:
  - s_axis_dout_tready=1.
  - On each handshake: compare tdata with the expected word; on mismatch, word_err increments (16-bit, saturating). Then advance the LFSR and increment beat_cnt.
  - tlast on beat index < len-1: set short_err, go to STATUS.
  - Beat index == len-1 with tlast: go to STATUS.
  - Beat index == len-1 without tlast: set long_err, go to DRAIN.
- DRAIN:
  - s_axis_dout_tready=1.
  - Extra beats are discarded: no compare, no LFSR advance.
  - On a tlast handshake, go to STATUS.
- STATUS:
  - s_axis_status_tready=1.
  - On handshake: dec_fail = tdata[0]; go to RESULT.
- RESULT:
  - Registered result tdata:
    - [15:0] word_err
    - [16] short_err
    - [17] long_err
    - [18] dec_fail
    - [23:19] 0
    - [31:24] block index [7:0] (0-based)
  - tvalid=1; tdata and tlast are held stable until the handshake.
  - On handshake:
    - err_block_cnt increments if any of [18:0] is nonzero.
    - If this was the last block: done=1 for one cycle, go to IDLE.
    - Otherwise: clear the per-block fields and go to DATA.
- The data and status inputs are never ready in the same cycle.
- Input tready is 0 while the result is stalled, which back-pressures the loop.
- Latency: the result becomes valid 2 cycles after the data tlast handshake, given the status is already valid.
- cfg_start while busy is ignored. Config inputs are sampled only on an accepted start.

Test Plan:
1. seed=1, len=4, blocks=1; data 0x00000001, 0x80200003, 0xC0300002, 0x60180001 with tlast on the 4th beat; status 0 -> result 0x0000_0000 with tlast=1, done pulse, err_block_cnt=0.
2. Same as 1, but the 3rd beat is 0xC0300003 -> result 0x0000_0001, err_block_cnt=1.
3. len=4, tlast on the 2nd beat (correct data), status 0 -> result 0x0001_0000; the next block's first expected word is 0xC0300002.
4. len=4, 6 beats with tlast on the 6th, status 1 -> result 0x0006_0000; beats 5-6 are ignored; the LFSR stands at 0x60180001's successor.
5. blocks=2, m_axis_result_tready=0 for 5 cycles after the first result -> tvalid and tdata are held, s_axis_dout_tready stays 0; second result tdata[31:24]=0x01 with tlast=1.
6. aresetn low for 1 cycle after 2 beats of a block, then restart with seed=1 -> no result for the aborted block; the first expected word is 0x00000001 again; busy and err_block_cnt are cleared.
